// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of the SDRAM controller slave. Captures one command at a
// time and tracks outstanding reads in a tag FIFO so read data returns to the issuing port.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned PRIO_MODE   = 0
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   rq0_address,
  input  logic                rq0_read,
  input  logic                rq0_write,
  input  logic [DATA_W-1:0]   rq0_writedata,
  input  logic [DATA_W/8-1:0] rq0_byteenable,
  output logic                rq0_waitrequest,
  output logic [DATA_W-1:0]   rq0_readdata,
  output logic                rq0_readdatavalid,
  input  logic [ADDR_W-1:0]   rq1_address,
  input  logic                rq1_read,
  input  logic                rq1_write,
  input  logic [DATA_W-1:0]   rq1_writedata,
  input  logic [DATA_W/8-1:0] rq1_byteenable,
  output logic                rq1_waitrequest,
  output logic [DATA_W-1:0]   rq1_readdata,
  output logic                rq1_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [1:0]          grant_o,
  output logic                err_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(MAX_PENDING);
  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_PENDING);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e state_q, state_d;

  logic [MAX_PENDING-1:0] tag_mem_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   last_q;

  logic [1:0]        elig;
  logic              cap, win_id;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_writedata;
  logic [BE_W-1:0]   sel_byteenable;
  logic              sel_read, sel_write;
  logic              push, pop, head;

  // Writes never occupy a tag slot, so only reads are held off by a full FIFO.
  always_comb begin
    elig[0] = rq0_write | (rq0_read & (cnt_q < CntMax));
    elig[1] = rq1_write | (rq1_read & (cnt_q < CntMax));
    cap     = (state_q == StIdle) && (elig != 2'b00);
    win_id  = elig[1];
    if (elig == 2'b11) begin
      win_id = (PRIO_MODE != 0) ? 1'b0 : ~last_q;
    end
  end

  always_comb begin
    sel_address    = win_id ? rq1_address    : rq0_address;
    sel_writedata  = win_id ? rq1_writedata  : rq0_writedata;
    sel_byteenable = win_id ? rq1_byteenable : rq0_byteenable;
    sel_read       = win_id ? rq1_read       : rq0_read;
    sel_write      = win_id ? rq1_write      : rq0_write;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cap) state_d = StIssue;
      StIssue: if (!m_waitrequest) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rq0_waitrequest = 1'b1;
    rq1_waitrequest = 1'b1;
    if (reset_reset_n && cap) begin
      if (win_id) rq1_waitrequest = 1'b0;
      else        rq0_waitrequest = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      m_address    <= '0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      grant_o      <= 2'b00;
      last_q       <= 1'b1;
    end else if (cap) begin
      m_address    <= sel_address;
      m_writedata  <= sel_writedata;
      m_byteenable <= sel_byteenable;
      m_read       <= sel_read;
      m_write      <= sel_write;
      grant_o      <= win_id ? 2'b10 : 2'b01;
      last_q       <= win_id;
    end else if (state_q == StIssue && !m_waitrequest) begin
      m_read  <= 1'b0;
      m_write <= 1'b0;
      grant_o <= 2'b00;
    end
  end

  assign push = cap & sel_read;
  assign pop  = m_readdatavalid & (cnt_q != '0);
  assign head = tag_mem_q[rd_ptr_q];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tag_mem_q         <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      cnt_q             <= '0;
      err_o             <= 1'b0;
      rq0_readdatavalid <= 1'b0;
      rq1_readdatavalid <= 1'b0;
      rq0_readdata      <= '0;
      rq1_readdata      <= '0;
    end else begin
      if (push) begin
        tag_mem_q[wr_ptr_q] <= win_id;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // A beat with nothing outstanding is dropped and latched as an error.
      if (m_readdatavalid && cnt_q == '0) begin
        err_o <= 1'b1;
      end
      rq0_readdatavalid <= pop & ~head;
      rq1_readdatavalid <= pop & head;
      if (pop && !head) rq0_readdata <= m_readdata;
      if (pop && head)  rq1_readdata <= m_readdata;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: cycle table, directed corner sequences, and a randomized run
// checked against a queue-based reference model.
module tb_sdram_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int MP = 4;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [AW-1:0] rq0_address, rq1_address;
  logic          rq0_read, rq0_write, rq1_read, rq1_write;
  logic [DW-1:0] rq0_writedata, rq1_writedata;
  logic [BW-1:0] rq0_byteenable, rq1_byteenable;
  logic          m_waitrequest, m_readdatavalid;
  logic [DW-1:0] m_readdata;

  logic          rq0_waitrequest, rq1_waitrequest, rq0_readdatavalid, rq1_readdatavalid;
  logic [DW-1:0] rq0_readdata, rq1_readdata, m_writedata;
  logic [AW-1:0] m_address;
  logic          m_read, m_write, err_o;
  logic [BW-1:0] m_byteenable;
  logic [1:0]    grant_o;

  logic          p_rq0_waitrequest, p_rq1_waitrequest, p_rq0_readdatavalid, p_rq1_readdatavalid;
  logic [DW-1:0] p_rq0_readdata, p_rq1_readdata, p_m_writedata;
  logic [AW-1:0] p_m_address;
  logic          p_m_read, p_m_write, p_err_o;
  logic [BW-1:0] p_m_byteenable;
  logic [1:0]    p_grant_o;

  always #5 clk_clk = ~clk_clk;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP), .PRIO_MODE(0)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .rq0_address(rq0_address), .rq0_read(rq0_read), .rq0_write(rq0_write),
    .rq0_writedata(rq0_writedata), .rq0_byteenable(rq0_byteenable),
    .rq0_waitrequest(rq0_waitrequest), .rq0_readdata(rq0_readdata),
    .rq0_readdatavalid(rq0_readdatavalid),
    .rq1_address(rq1_address), .rq1_read(rq1_read), .rq1_write(rq1_write),
    .rq1_writedata(rq1_writedata), .rq1_byteenable(rq1_byteenable),
    .rq1_waitrequest(rq1_waitrequest), .rq1_readdata(rq1_readdata),
    .rq1_readdatavalid(rq1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .grant_o(grant_o), .err_o(err_o)
  );

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP), .PRIO_MODE(1)) dut_p (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .rq0_address(rq0_address), .rq0_read(rq0_read), .rq0_write(rq0_write),
    .rq0_writedata(rq0_writedata), .rq0_byteenable(rq0_byteenable),
    .rq0_waitrequest(p_rq0_waitrequest), .rq0_readdata(p_rq0_readdata),
    .rq0_readdatavalid(p_rq0_readdatavalid),
    .rq1_address(rq1_address), .rq1_read(rq1_read), .rq1_write(rq1_write),
    .rq1_writedata(rq1_writedata), .rq1_byteenable(rq1_byteenable),
    .rq1_waitrequest(p_rq1_waitrequest), .rq1_readdata(p_rq1_readdata),
    .rq1_readdatavalid(p_rq1_readdatavalid),
    .m_address(p_m_address), .m_read(p_m_read), .m_write(p_m_write),
    .m_writedata(p_m_writedata), .m_byteenable(p_m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .grant_o(p_grant_o), .err_o(p_err_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_clk);
  endtask

  task automatic quiet();
    rq0_read = 1'b0; rq0_write = 1'b0; rq1_read = 1'b0; rq1_write = 1'b0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
  endtask

  task automatic fixed_fields();
    rq0_address = 25'h0000123; rq0_writedata = 16'hBEEF; rq0_byteenable = 2'b11;
    rq1_address = 25'h1ABCDEF; rq1_writedata = 16'h1234; rq1_byteenable = 2'b10;
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    quiet();
    repeat (2) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
  endtask

  // stim = {r0,w0,r1,w1,m_waitrequest,m_readdatavalid}; exp = {wq0,wq1,grant,m_read,m_write,rv0,rv1}
  typedef struct packed {
    logic [5:0] stim;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic run_table();
    tbl[0] = '{stim: 6'b010000, exp: 8'b01_00_0000};
    tbl[1] = '{stim: 6'b000000, exp: 8'b11_01_0100};
    tbl[2] = '{stim: 6'b101010, exp: 8'b10_00_0000};
    tbl[3] = '{stim: 6'b101010, exp: 8'b11_10_1000};
    tbl[4] = '{stim: 6'b101000, exp: 8'b11_10_1000};
    tbl[5] = '{stim: 6'b101000, exp: 8'b01_00_0000};
    tbl[6] = '{stim: 6'b000000, exp: 8'b11_01_1000};
    tbl[7] = '{stim: 6'b000101, exp: 8'b10_00_0000};
    tbl[8] = '{stim: 6'b000001, exp: 8'b11_10_0101};
    tbl[9] = '{stim: 6'b000000, exp: 8'b11_00_0010};
    do_reset();
    check("reset_state", 64'({rq0_waitrequest, rq1_waitrequest, grant_o, m_read, m_write,
                              rq0_readdatavalid, rq1_readdatavalid, err_o}), 64'(9'b11_00_0000_0));
    for (int i = 0; i < 10; i++) begin
      {rq0_read, rq0_write, rq1_read, rq1_write, m_waitrequest, m_readdatavalid} = tbl[i].stim;
      m_readdata = 16'(16'hA000 + i);
      mid();
      check($sformatf("vec%0d", i), 64'({rq0_waitrequest, rq1_waitrequest, grant_o, m_read,
                                         m_write, rq0_readdatavalid, rq1_readdatavalid}),
            64'(tbl[i].exp));
      next_cycle();
    end
    quiet();
    check("table_err", 64'(err_o), 64'(0));
  endtask

  task automatic seq_write_fields();
    do_reset();
    rq0_write = 1'b1;
    mid();
    check("wr_wait", 64'({rq0_waitrequest, rq1_waitrequest}), 64'(2'b01));
    next_cycle();
    rq0_write = 1'b0;
    mid();
    check("wr_fields", 64'({m_write, m_read, grant_o, m_address, m_writedata, m_byteenable}),
          64'({1'b1, 1'b0, 2'b01, 25'h0000123, 16'hBEEF, 2'b11}));
    next_cycle();
    mid();
    check("wr_done", 64'({m_write, grant_o}), 64'(0));
    next_cycle();
  endtask

  task automatic seq_rr_vs_prio();
    logic [1:0] g_rr[$];
    logic [1:0] g_pr[$];
    do_reset();
    rq0_read = 1'b1; rq1_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mid();
      if (grant_o != 2'b00) g_rr.push_back(grant_o);
      if (p_grant_o != 2'b00) g_pr.push_back(p_grant_o);
      next_cycle();
    end
    rq0_read = 1'b0; rq1_read = 1'b0;
    check("rr_count", 64'(g_rr.size()), 64'(4));
    check("prio_count", 64'(g_pr.size()), 64'(4));
    for (int k = 0; k < 4 && k < g_rr.size() && k < g_pr.size(); k++) begin
      check($sformatf("rr_grant%0d", k), 64'(g_rr[k]), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
      check($sformatf("prio_grant%0d", k), 64'(g_pr[k]), 64'(2'b01));
    end
    m_readdatavalid = 1'b1;
    repeat (4) next_cycle();
    m_readdatavalid = 1'b0;
    next_cycle();
    check("rr_drain_err", 64'({err_o, p_err_o}), 64'(0));
  endtask

  task automatic seq_stall();
    do_reset();
    rq1_write = 1'b1; m_waitrequest = 1'b1;
    mid();
    check("stall_cap", 64'(rq1_waitrequest), 64'(0));
    next_cycle();
    rq1_write = 1'b0; rq0_read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      m_waitrequest = (k < 5);
      mid();
      check($sformatf("stall_hold%0d", k),
            64'({m_write, m_read, grant_o, rq0_waitrequest, m_address, m_writedata, m_byteenable}),
            64'({1'b1, 1'b0, 2'b10, 1'b1, 25'h1ABCDEF, 16'h1234, 2'b10}));
      next_cycle();
    end
    m_waitrequest = 1'b0;
    mid();
    check("stall_next_cap", 64'(rq0_waitrequest), 64'(0));
    next_cycle();
    rq0_read = 1'b0;
    mid();
    check("stall_read_issued", 64'({m_read, grant_o, m_address}), 64'({1'b1, 2'b01, 25'h0000123}));
    next_cycle();
  endtask

  task automatic seq_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rq0_read = 1'b1;
      next_cycle();
      rq0_read = 1'b0;
      next_cycle();
    end
    rq0_read = 1'b1; rq1_write = 1'b1;
    mid();
    check("full_block", 64'({rq0_waitrequest, rq1_waitrequest}), 64'(2'b10));
    next_cycle();
    rq1_write = 1'b0; m_readdatavalid = 1'b1; m_readdata = 16'h5A5A;
    mid();
    check("full_issue_write", 64'({m_write, grant_o, rq0_waitrequest}), 64'({1'b1, 2'b10, 1'b1}));
    next_cycle();
    m_readdatavalid = 1'b0;
    mid();
    check("full_unblock", 64'({rq0_waitrequest, rq0_readdatavalid, rq1_readdatavalid, rq0_readdata}),
          64'({1'b0, 1'b1, 1'b0, 16'h5A5A}));
    next_cycle();
    rq0_read = 1'b0;
    mid();
    check("full_read_issued", 64'({m_read, grant_o}), 64'({1'b1, 2'b01}));
    next_cycle();
  endtask

  task automatic seq_interleave();
    logic [DW-1:0] got0[$];
    logic [DW-1:0] got1[$];
    int nvalid;
    int order[4];
    order[0] = 0; order[1] = 1; order[2] = 1; order[3] = 0;
    nvalid = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (order[k] == 0) rq0_read = 1'b1; else rq1_read = 1'b1;
      next_cycle();
      rq0_read = 1'b0; rq1_read = 1'b0;
      next_cycle();
    end
    for (int k = 0; k < 7; k++) begin
      m_readdatavalid = (k < 4);
      m_readdata = 16'(k + 1);
      mid();
      if (rq0_readdatavalid) got0.push_back(rq0_readdata);
      if (rq1_readdatavalid) got1.push_back(rq1_readdata);
      if (rq0_readdatavalid || rq1_readdatavalid) nvalid++;
      next_cycle();
    end
    check("il_beats", 64'(nvalid), 64'(4));
    check("il_count0", 64'(got0.size()), 64'(2));
    check("il_count1", 64'(got1.size()), 64'(2));
    if (got0.size() == 2) check("il_port0", 64'({got0[0], got0[1]}), 64'({16'h0001, 16'h0004}));
    if (got1.size() == 2) check("il_port1", 64'({got1[0], got1[1]}), 64'({16'h0002, 16'h0003}));
    check("il_err", 64'(err_o), 64'(0));
  endtask

  task automatic seq_reset_mid();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      rq0_read = 1'b1;
      next_cycle();
      rq0_read = 1'b0;
      next_cycle();
    end
    rq1_write = 1'b1; m_waitrequest = 1'b1;
    next_cycle();
    rq1_write = 1'b0;
    mid();
    check("rst_pre_issue", 64'({m_write, grant_o}), 64'({1'b1, 2'b10}));
    #1 reset_reset_n = 1'b0;
    rq0_write = 1'b1;
    #1;
    check("rst_ctrl", 64'({m_read, m_write, grant_o, err_o, rq0_waitrequest, rq1_waitrequest,
                           rq0_readdatavalid, rq1_readdatavalid}), 64'(9'b0_0_00_0_11_00));
    check("rst_data", 64'({m_address, m_writedata, m_byteenable}), 64'(0));
    check("rst_rdata", 64'({rq0_readdata, rq1_readdata}), 64'(0));
    quiet();
    repeat (2) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    m_readdatavalid = 1'b1; m_readdata = 16'hDEAD;
    next_cycle();
    m_readdatavalid = 1'b0;
    mid();
    check("stray_err", 64'({err_o, rq0_readdatavalid, rq1_readdatavalid}), 64'(3'b100));
    next_cycle();
    mid();
    check("stray_sticky", 64'({err_o, rq0_readdatavalid, rq1_readdatavalid}), 64'(3'b100));
    next_cycle();
  endtask

  task automatic run_random(input int ncycles);
    bit            busy, e_rd, e_wr, e_err;
    bit [1:0]      e_grant, e_rv;
    bit [AW-1:0]   e_addr;
    bit [DW-1:0]   e_wd;
    bit [BW-1:0]   e_be;
    bit [DW-1:0]   e_rdata[2];
    int            last, w, p;
    int            mq[$];
    bit            elig0, elig1;
    int            c0, c1;
    busy = 0; e_rd = 0; e_wr = 0; e_err = 0; e_grant = 0; e_rv = 0;
    e_addr = 0; e_wd = 0; e_be = 0; e_rdata[0] = 0; e_rdata[1] = 0; last = 1;
    do_reset();
    for (int cyc = 0; cyc < ncycles; cyc++) begin
      c0 = $urandom_range(0, 3);
      c1 = $urandom_range(0, 3);
      rq0_read = (c0 == 2); rq0_write = (c0 == 3);
      rq1_read = (c1 == 2); rq1_write = (c1 == 3);
      rq0_address = AW'($urandom); rq1_address = AW'($urandom);
      rq0_writedata = DW'($urandom); rq1_writedata = DW'($urandom);
      rq0_byteenable = BW'($urandom); rq1_byteenable = BW'($urandom);
      m_waitrequest = ($urandom_range(0, 2) == 0);
      m_readdatavalid = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
      m_readdata = DW'($urandom);
      mid();
      elig0 = rq0_write || (rq0_read && mq.size() < MP);
      elig1 = rq1_write || (rq1_read && mq.size() < MP);
      w = -1;
      if (!busy) begin
        if (elig0 && elig1) w = (last == 1) ? 0 : 1;
        else if (elig0) w = 0;
        else if (elig1) w = 1;
      end
      check("rnd_wait", 64'({rq0_waitrequest, rq1_waitrequest}), 64'({w != 0, w != 1}));
      check("rnd_cmd", 64'({m_read, m_write, grant_o}), 64'({e_rd, e_wr, e_grant}));
      if (e_rd || e_wr)
        check("rnd_fields", 64'({m_address, m_writedata, m_byteenable}), 64'({e_addr, e_wd, e_be}));
      check("rnd_rv", 64'({rq1_readdatavalid, rq0_readdatavalid}), 64'(e_rv));
      if (e_rv[0]) check("rnd_rdata0", 64'(rq0_readdata), 64'(e_rdata[0]));
      if (e_rv[1]) check("rnd_rdata1", 64'(rq1_readdata), 64'(e_rdata[1]));
      check("rnd_err", 64'(err_o), 64'(e_err));
      e_rv = 0;
      if (m_readdatavalid) begin
        if (mq.size() == 0) begin
          e_err = 1;
        end else begin
          p = mq.pop_front();
          e_rv[p] = 1'b1;
          e_rdata[p] = m_readdata;
        end
      end
      if (busy) begin
        if (!m_waitrequest) begin
          busy = 0; e_rd = 0; e_wr = 0; e_grant = 0;
        end
      end else if (w >= 0) begin
        busy = 1;
        last = w;
        e_grant = (w == 1) ? 2'b10 : 2'b01;
        e_addr = (w == 1) ? rq1_address : rq0_address;
        e_wd   = (w == 1) ? rq1_writedata : rq0_writedata;
        e_be   = (w == 1) ? rq1_byteenable : rq0_byteenable;
        e_rd   = (w == 1) ? rq1_read : rq0_read;
        e_wr   = (w == 1) ? rq1_write : rq0_write;
        if (e_rd) mq.push_back(w);
      end
      next_cycle();
    end
    quiet();
  endtask

  initial begin
    reset_reset_n = 1'b0;
    quiet();
    fixed_fields();
    run_table();
    seq_write_fields();
    seq_rr_vs_prio();
    seq_stall();
    seq_full();
    seq_interleave();
    seq_reset_mid();
    run_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
